// File: rtl/axis_buf_pkg.sv
`default_nettype none
// ============================================================================
// Package  : axis_buf_pkg
// Brief    : Shared types and word-layout helpers for the AXI-Stream packet
//            buffer. Memory word layout is {tlast, tstrb, tdata}.
// Revision : 1.0
// ============================================================================
package axis_buf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PKT  = 2'b01,
        DROP = 2'b10
    } wr_state_t;

    localparam int WORD_DATA_OFS = 0;

    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int word_strb_ofs(input int data_width);
        return WORD_DATA_OFS + data_width;
    endfunction

    function automatic int word_last_ofs(input int data_width);
        return word_strb_ofs(data_width) + strb_width(data_width);
    endfunction

    function automatic int word_width(input int data_width);
        return word_last_ofs(data_width) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_buf_ram.sv
`default_nettype none
// ============================================================================
// Module   : axis_buf_ram
// Brief    : Simple dual-port RAM, one write port and one registered read
//            port with read-enable. The read register resets to zero.
// Revision : 1.0
// ============================================================================
module axis_buf_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int WORD_WIDTH = 37
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [WORD_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [WORD_WIDTH-1:0] o_rd_data
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [WORD_WIDTH-1:0] mem [DEPTH];
    logic [WORD_WIDTH-1:0] rd_data_q;
    logic [WORD_WIDTH-1:0] rd_data_d;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (i_rd_en) begin
            rd_data_d = mem[i_rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign o_rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/axis_pkt_buffer.sv
`default_nettype none
// ============================================================================
// Module   : axis_pkt_buffer
// Brief    : Store-and-forward AXI-Stream packet buffer. Define
//            AXIS_BUF_DROP_EN to discard overflowing packets instead of
//            back-pressuring the slave port.
// Revision : 1.0
// ============================================================================
module axis_pkt_buffer
    import axis_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                    axis_aclk,
    input  logic                    axis_aresetn,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    output logic [ADDR_WIDTH:0]     fill_level,
    output logic [ADDR_WIDTH:0]     pkt_count,
    output logic                    drop_pulse
);
    localparam int STRB_WIDTH = strb_width(DATA_WIDTH);
    localparam int WORD_WIDTH = word_width(DATA_WIDTH);
    localparam int STRB_OFS   = word_strb_ofs(DATA_WIDTH);
    localparam int LAST_OFS   = word_last_ofs(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0] PTR_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    wr_state_t             state_q, state_d;
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   wr_commit_q, wr_commit_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   pkt_count_q, pkt_count_d;
    logic                  ready_en_q, ready_en_d;
    logic                  m_valid_q, m_valid_d;
    logic                  w_full;
    logic                  w_s_accept;
    logic                  w_wr_en;
    logic                  w_commit;
    logic                  w_rd_en;
    logic                  w_m_last_hs;
    logic [WORD_WIDTH-1:0] w_wr_word;
    logic [WORD_WIDTH-1:0] w_rd_word;
`ifdef AXIS_BUF_DROP_EN
    logic                  drop_pulse_q, drop_pulse_d;
`endif

    // MSB of the pointers distinguishes full from empty.
    assign fill_level = wr_ptr_q - rd_ptr_q;
    assign w_full     = (fill_level == PTR_FULL);

`ifdef AXIS_BUF_DROP_EN
    assign s_axis_tready = ready_en_q;
    assign drop_pulse    = drop_pulse_q;
`else
    assign s_axis_tready = ready_en_q && !w_full;
    assign drop_pulse    = 1'b0;
`endif

    assign w_s_accept = s_axis_tvalid && s_axis_tready;
    assign w_wr_word  = {s_axis_tlast, s_axis_tstrb, s_axis_tdata};

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        w_wr_en     = 1'b0;
        w_commit    = 1'b0;
`ifdef AXIS_BUF_DROP_EN
        drop_pulse_d = 1'b0;
`endif
        if (w_s_accept) begin
`ifdef AXIS_BUF_DROP_EN
            // Overflow rewinds to the last commit, discarding the partial packet.
            if (state_q == DROP || w_full) begin
                wr_ptr_d     = wr_commit_q;
                state_d      = s_axis_tlast ? IDLE : DROP;
                drop_pulse_d = s_axis_tlast;
            end else
`endif
            begin
                w_wr_en  = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                if (s_axis_tlast) begin
                    wr_commit_d = wr_ptr_q + PTR_ONE;
                    w_commit    = 1'b1;
                    state_d     = IDLE;
                end else begin
                    state_d = PKT;
                end
            end
        end
    end

    // Only committed words are eligible for the output register.
    assign w_rd_en     = (!m_valid_q || m_axis_tready) && (rd_ptr_q != wr_commit_q);
    assign w_m_last_hs = m_valid_q && m_axis_tready && m_axis_tlast;

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        m_valid_d   = m_valid_q;
        pkt_count_d = pkt_count_q;
        ready_en_d  = 1'b1;
        if (w_rd_en) begin
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
            m_valid_d = 1'b1;
        end else if (m_axis_tready) begin
            m_valid_d = 1'b0;
        end
        case ({w_commit, w_m_last_hs})
            2'b10:   pkt_count_d = pkt_count_q + PTR_ONE;
            2'b01:   pkt_count_d = pkt_count_q - PTR_ONE;
            default: pkt_count_d = pkt_count_q;
        endcase
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            pkt_count_q <= '0;
            ready_en_q  <= 1'b0;
            m_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            rd_ptr_q    <= rd_ptr_d;
            pkt_count_q <= pkt_count_d;
            ready_en_q  <= ready_en_d;
            m_valid_q   <= m_valid_d;
        end
    end

`ifdef AXIS_BUF_DROP_EN
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            drop_pulse_q <= 1'b0;
        end else begin
            drop_pulse_q <= drop_pulse_d;
        end
    end
`endif

    axis_buf_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_ram (
        .clk       (axis_aclk),
        .rst_n     (axis_aresetn),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .i_wr_data (w_wr_word),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .o_rd_data (w_rd_word)
    );

    assign m_axis_tdata  = w_rd_word[WORD_DATA_OFS +: DATA_WIDTH];
    assign m_axis_tstrb  = w_rd_word[STRB_OFS +: STRB_WIDTH];
    assign m_axis_tlast  = w_rd_word[LAST_OFS];
    assign m_axis_tvalid = m_valid_q;
    assign pkt_count     = pkt_count_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_pkt_buffer
// Brief    : Scoreboard bench for axis_pkt_buffer at ADDR_WIDTH=2 (DEPTH=4);
//            overflow scenario follows AXIS_BUF_DROP_EN.
// Revision : 1.0
// ============================================================================
module tb_axis_pkt_buffer;
    localparam int DW    = 32;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;
    localparam int SW    = DW / 8;
    localparam int WW    = DW + SW + 1;

    logic          axis_aclk = 1'b0;
    logic          axis_aresetn;
    logic [DW-1:0] s_axis_tdata;
    logic [SW-1:0] s_axis_tstrb;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [SW-1:0] m_axis_tstrb;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;
    logic [AW:0]   fill_level;
    logic [AW:0]   pkt_count;
    logic          drop_pulse;

    int            n_cmp  = 0;
    int            n_fail = 0;
    logic [WW-1:0] sb [$];
    logic [WW-1:0] exp_w;
    logic [WW-1:0] got_w;

    axis_pkt_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .axis_aclk     (axis_aclk),
        .axis_aresetn  (axis_aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tstrb  (s_axis_tstrb),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .fill_level    (fill_level),
        .pkt_count     (pkt_count),
        .drop_pulse    (drop_pulse)
    );

    always #5 axis_aclk = ~axis_aclk;

    task automatic idle_in();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tstrb  = '0;
    endtask

    // Drive one beat; the expectation is queued only if the beat is accepted and kept.
    task automatic offer(input logic last, input logic [DW-1:0] d, input logic [SW-1:0] s,
                         input bit keep, output bit acc);
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = last;
        s_axis_tdata  = d;
        s_axis_tstrb  = s;
        acc = s_axis_tready;
        if (acc && keep) sb.push_back({last, s, d});
    endtask

    task automatic test_reset();
        axis_aresetn  = 1'b0;
        m_axis_tready = 1'b0;
        idle_in();
        repeat (3) @(negedge axis_aclk);
        n_cmp++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL rst_s_tready: got %b want 0", s_axis_tready); end
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_m_tvalid: got %b want 0", m_axis_tvalid); end
        n_cmp++; if (m_axis_tdata !== '0) begin n_fail++; $display("FAIL rst_m_tdata: got %h want 0", m_axis_tdata); end
        n_cmp++; if (m_axis_tstrb !== '0) begin n_fail++; $display("FAIL rst_m_tstrb: got %h want 0", m_axis_tstrb); end
        n_cmp++; if (m_axis_tlast !== 1'b0) begin n_fail++; $display("FAIL rst_m_tlast: got %b want 0", m_axis_tlast); end
        n_cmp++; if (fill_level !== '0) begin n_fail++; $display("FAIL rst_fill: got %0d want 0", fill_level); end
        n_cmp++; if (pkt_count !== '0) begin n_fail++; $display("FAIL rst_pkt: got %0d want 0", pkt_count); end
        n_cmp++; if (drop_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_drop: got %b want 0", drop_pulse); end
        axis_aresetn = 1'b1;
        #1;
        n_cmp++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL rel_ready_early: got %b want 0", s_axis_tready); end
        @(negedge axis_aclk);
        n_cmp++; if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL rel_ready: got %b want 1", s_axis_tready); end
    endtask

    task automatic test_basic();
        bit acc;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge axis_aclk);
            offer(i == 3, 32'h11 + i, 4'hF, 1'b1, acc);
            n_cmp++; if (!acc) begin n_fail++; $display("FAIL basic_accept: beat %0d got ready 0 want 1", i); end
        end
        @(negedge axis_aclk);
        idle_in();
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL basic_lat_early: got %b want 0", m_axis_tvalid); end
        n_cmp++; if (pkt_count !== 3'd1) begin n_fail++; $display("FAIL basic_pkt1: got %0d want 1", pkt_count); end
        for (int c = 0; c < 8; c++) begin
            @(negedge axis_aclk);
            if (c == 0) begin
                n_cmp++; if (m_axis_tvalid !== 1'b1) begin n_fail++; $display("FAIL basic_lat: got %b want 1", m_axis_tvalid); end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                got_w = {m_axis_tlast, m_axis_tstrb, m_axis_tdata};
                n_cmp++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL basic_out: got %h want nothing", got_w); end
                else begin
                    exp_w = sb.pop_front();
                    if (got_w !== exp_w) begin n_fail++; $display("FAIL basic_out: got %h want %h", got_w, exp_w); end
                end
            end
        end
        n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL basic_drain: got %0d pending want 0", sb.size()); end
        n_cmp++; if (pkt_count !== 3'd0) begin n_fail++; $display("FAIL basic_pkt0: got %0d want 0", pkt_count); end
    endtask

    task automatic test_partial();
        bit acc;
        bit seen;
        m_axis_tready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge axis_aclk);
            offer(1'b0, 32'h21 + i, 4'(i + 5), 1'b1, acc);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge axis_aclk);
            idle_in();
            if (m_axis_tvalid) seen = 1'b1;
        end
        n_cmp++; if (seen) begin n_fail++; $display("FAIL partial_valid: got tvalid 1 want 0"); end
        n_cmp++; if (fill_level !== 3'd3) begin n_fail++; $display("FAIL partial_fill: got %0d want 3", fill_level); end
        @(negedge axis_aclk);
        offer(1'b1, 32'h24, 4'h8, 1'b1, acc);
        for (int c = 0; c < 10; c++) begin
            @(negedge axis_aclk);
            idle_in();
            if (m_axis_tvalid && m_axis_tready) begin
                got_w = {m_axis_tlast, m_axis_tstrb, m_axis_tdata};
                n_cmp++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL partial_out: got %h want nothing", got_w); end
                else begin
                    exp_w = sb.pop_front();
                    if (got_w !== exp_w) begin n_fail++; $display("FAIL partial_out: got %h want %h", got_w, exp_w); end
                end
            end
        end
        n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL partial_drain: got %0d pending want 0", sb.size()); end
        n_cmp++; if (fill_level !== 3'd0) begin n_fail++; $display("FAIL partial_fill0: got %0d want 0", fill_level); end
    endtask

`ifndef AXIS_BUF_DROP_EN
    task automatic test_backpressure();
        bit acc;
        int k;
        k = 0;
        m_axis_tready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge axis_aclk);
            offer(1'b1, 32'h30 + k, 4'hF, 1'b1, acc);
            if (acc) k++;
        end
        @(negedge axis_aclk);
        n_cmp++; if (k != DEPTH + 1) begin n_fail++; $display("FAIL bp_accepted: got %0d want %0d", k, DEPTH + 1); end
        n_cmp++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b want 0", s_axis_tready); end
        n_cmp++; if (fill_level !== 3'(DEPTH)) begin n_fail++; $display("FAIL bp_fill: got %0d want %0d", fill_level, DEPTH); end
        n_cmp++; if (pkt_count !== 3'(DEPTH + 1)) begin n_fail++; $display("FAIL bp_pkt: got %0d want %0d", pkt_count, DEPTH + 1); end
        n_cmp++; if (m_axis_tdata !== 32'h30) begin n_fail++; $display("FAIL bp_hold: got %h want 00000030", m_axis_tdata); end
        offer(1'b1, 32'h30 + k, 4'hF, 1'b1, acc);
        if (acc) k++;
        m_axis_tready = 1'b1;
        if (m_axis_tvalid && m_axis_tready) begin
            got_w = {m_axis_tlast, m_axis_tstrb, m_axis_tdata};
            n_cmp++;
            if (sb.size() == 0) begin n_fail++; $display("FAIL bp_out: got %h want nothing", got_w); end
            else begin
                exp_w = sb.pop_front();
                if (got_w !== exp_w) begin n_fail++; $display("FAIL bp_out: got %h want %h", got_w, exp_w); end
            end
        end
        @(negedge axis_aclk);
        m_axis_tready = 1'b0;
        n_cmp++; if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL bp_resume: got %b want 1", s_axis_tready); end
        offer(1'b1, 32'h30 + k, 4'hF, 1'b1, acc);
        for (int c = 0; c < 12; c++) begin
            @(negedge axis_aclk);
            idle_in();
            m_axis_tready = 1'b1;
            if (m_axis_tvalid && m_axis_tready) begin
                got_w = {m_axis_tlast, m_axis_tstrb, m_axis_tdata};
                n_cmp++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL bp_out: got %h want nothing", got_w); end
                else begin
                    exp_w = sb.pop_front();
                    if (got_w !== exp_w) begin n_fail++; $display("FAIL bp_out: got %h want %h", got_w, exp_w); end
                end
            end
        end
        n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL bp_drain: got %0d pending want 0", sb.size()); end
        n_cmp++; if (pkt_count !== 3'd0) begin n_fail++; $display("FAIL bp_pkt0: got %0d want 0", pkt_count); end
    endtask
`endif

`ifdef AXIS_BUF_DROP_EN
    task automatic test_drop();
        bit acc;
        int nrej, drops, peak;
        nrej = 0; drops = 0; peak = 0;
        m_axis_tready = 1'b0;
        for (int c = 0; c < 13; c++) begin
            @(negedge axis_aclk);
            if (drop_pulse) drops++;
            if (int'(pkt_count) > peak) peak = int'(pkt_count);
            if (c < 7) offer(c == 6, 32'h41 + c, 4'hF, 1'b0, acc);
            else if (c < 9) offer(c == 8, 32'h51 + c - 7, 4'hC, 1'b1, acc);
            else begin idle_in(); acc = 1'b1; end
            if (!acc) nrej++;
        end
        n_cmp++; if (nrej != 0) begin n_fail++; $display("FAIL drop_ready: got %0d refused beats want 0", nrej); end
        n_cmp++; if (drops != 1) begin n_fail++; $display("FAIL drop_pulses: got %0d want 1", drops); end
        n_cmp++; if (m_axis_tvalid !== 1'b1) begin n_fail++; $display("FAIL drop_valid: got %b want 1", m_axis_tvalid); end
        for (int c = 0; c < 8; c++) begin
            @(negedge axis_aclk);
            m_axis_tready = 1'b1;
            if (int'(pkt_count) > peak) peak = int'(pkt_count);
            if (m_axis_tvalid && m_axis_tready) begin
                got_w = {m_axis_tlast, m_axis_tstrb, m_axis_tdata};
                n_cmp++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL drop_out: got %h want nothing", got_w); end
                else begin
                    exp_w = sb.pop_front();
                    if (got_w !== exp_w) begin n_fail++; $display("FAIL drop_out: got %h want %h", got_w, exp_w); end
                end
            end
        end
        n_cmp++; if (peak != 1) begin n_fail++; $display("FAIL drop_pkt_peak: got %0d want 1", peak); end
        n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL drop_drain: got %0d pending want 0", sb.size()); end
        n_cmp++; if (pkt_count !== 3'd0) begin n_fail++; $display("FAIL drop_pkt0: got %0d want 0", pkt_count); end
    endtask
`endif

    task automatic test_back_to_back();
        bit acc;
        int nacc, nout, first, last, maxfill;
        nacc = 0; nout = 0; first = -1; last = -1; maxfill = 0;
        m_axis_tready = 1'b1;
        for (int c = 0; c < 3 * DEPTH + 8; c++) begin
            @(negedge axis_aclk);
            acc = 1'b0;
            if (c < 3 * DEPTH) offer(1'b1, 32'h60 + c, 4'(c), 1'b1, acc);
            else idle_in();
            if (acc) nacc++;
            if (int'(fill_level) > maxfill) maxfill = int'(fill_level);
            if (m_axis_tvalid && m_axis_tready) begin
                if (first < 0) first = c;
                last = c;
                nout++;
                got_w = {m_axis_tlast, m_axis_tstrb, m_axis_tdata};
                n_cmp++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL b2b_out: got %h want nothing", got_w); end
                else begin
                    exp_w = sb.pop_front();
                    if (got_w !== exp_w) begin n_fail++; $display("FAIL b2b_out: got %h want %h", got_w, exp_w); end
                end
            end
        end
        n_cmp++; if (nacc != 3 * DEPTH) begin n_fail++; $display("FAIL b2b_in_rate: got %0d accepted want %0d", nacc, 3 * DEPTH); end
        n_cmp++; if (nout != 3 * DEPTH) begin n_fail++; $display("FAIL b2b_out_count: got %0d want %0d", nout, 3 * DEPTH); end
        n_cmp++; if (last - first != 3 * DEPTH - 1) begin n_fail++; $display("FAIL b2b_out_rate: got span %0d want %0d", last - first, 3 * DEPTH - 1); end
        n_cmp++; if (maxfill > 2) begin n_fail++; $display("FAIL b2b_fill: got max %0d want <= 2", maxfill); end
        n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_drain: got %0d pending want 0", sb.size()); end
    endtask

    task automatic test_reset_mid_output();
        bit acc;
        m_axis_tready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge axis_aclk);
            offer(c == 1, 32'h81 + c, 4'hF, 1'b1, acc);
        end
        for (int c = 0; c < 5 && !m_axis_tvalid; c++) begin
            @(negedge axis_aclk);
            idle_in();
        end
        n_cmp++; if (m_axis_tvalid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b want 1", m_axis_tvalid); end
        #2 axis_aresetn = 1'b0;
        #1;
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL mid_async_valid: got %b want 0", m_axis_tvalid); end
        n_cmp++; if (pkt_count !== 3'd0) begin n_fail++; $display("FAIL mid_async_pkt: got %0d want 0", pkt_count); end
        n_cmp++; if (fill_level !== 3'd0) begin n_fail++; $display("FAIL mid_async_fill: got %0d want 0", fill_level); end
        n_cmp++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL mid_async_ready: got %b want 0", s_axis_tready); end
        sb.delete();
        repeat (2) @(negedge axis_aclk);
        axis_aresetn  = 1'b1;
        m_axis_tready = 1'b1;
        @(negedge axis_aclk);
        for (int c = 0; c < 3; c++) begin
            offer(c == 2, 32'h91 + c, 4'(9 + c), 1'b1, acc);
            n_cmp++; if (!acc) begin n_fail++; $display("FAIL mid_post_accept: beat %0d got ready 0 want 1", c); end
            @(negedge axis_aclk);
        end
        for (int c = 0; c < 10; c++) begin
            idle_in();
            if (m_axis_tvalid && m_axis_tready) begin
                got_w = {m_axis_tlast, m_axis_tstrb, m_axis_tdata};
                n_cmp++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL mid_out: got %h want nothing", got_w); end
                else begin
                    exp_w = sb.pop_front();
                    if (got_w !== exp_w) begin n_fail++; $display("FAIL mid_out: got %h want %h", got_w, exp_w); end
                end
            end
            @(negedge axis_aclk);
        end
        n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL mid_drain: got %0d pending want 0", sb.size()); end
        n_cmp++; if (pkt_count !== 3'd0) begin n_fail++; $display("FAIL mid_pkt0: got %0d want 0", pkt_count); end
    endtask

    initial begin
        axis_aresetn  = 1'b0;
        m_axis_tready = 1'b0;
        idle_in();
        test_reset();
        test_basic();
        test_partial();
`ifdef AXIS_BUF_DROP_EN
        test_drop();
`else
        test_backpressure();
`endif
        test_back_to_back();
        test_reset_mid_output();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
